// File: rtl/lbp_pkg.sv
// Shared types and image constants for the LBP gray-memory datapath.
package lbp_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int IMG_W  = 128;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/gray_mem_arbiter_rr_pick2.sv
// Two-way round-robin winner: a sole requester wins; on a tie the requester
// that did not own the memory last (not equal to rr_ptr) wins.
module rr_pick2
    import lbp_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    rr_ptr,
    output req_id_t    win
);

    always_comb begin
        win = REQ0;
        case (req)
            2'b10:   win = REQ1;
            2'b11:   win = ~rr_ptr;
            default: win = REQ0;
        endcase
    end

endmodule

// File: rtl/gray_mem_arbiter.sv
// Round-robin arbiter sharing the gray image memory between two requesters,
// with lock and burst-limited tenures. Optional per-requester beat counters: GRAY_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no owner, both grants low
// OWN   | owner register valid, owner's grant high
module gray_mem_arbiter
    import lbp_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 9,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    input  logic              r1_req,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
`ifdef GRAY_ARB_STATS_EN
    output logic [15:0]       r0_beats,
    output logic [15:0]       r1_beats,
`endif
    output logic              busy
);

    arb_state_t       state, state_n;
    req_id_t          owner, owner_n;
    req_id_t          rr_ptr, rr_ptr_n;
    req_id_t          win;
    logic [CNT_W-1:0] count, count_n;

    logic              own_req, own_lock, oth_req;
    logic [ADDR_W-1:0] own_addr;
    logic              accept, last_beat, rel_own;

    rr_pick2 u_pick (
        .req    ({r1_req, r0_req}),
        .rr_ptr (rr_ptr),
        .win    (win)
    );

    always_comb begin
        own_req   = (owner == REQ1) ? r1_req  : r0_req;
        own_lock  = (owner == REQ1) ? r1_lock : r0_lock;
        own_addr  = (owner == REQ1) ? r1_addr : r0_addr;
        oth_req   = (owner == REQ1) ? r0_req  : r1_req;
        accept    = (state == OWN) && own_req;
        // count holds beats already taken, so this beat is the MAX_BURST-th
        last_beat = accept && (count == CNT_W'(MAX_BURST - 1));
        rel_own   = (state == OWN) && ((!own_req && !own_lock) || last_beat);
    end

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        rr_ptr_n = rr_ptr;
        count_n  = count;
        case (state)
            IDLE: begin
                if (r0_req || r1_req) begin
                    state_n = OWN;
                    owner_n = win;
                    count_n = '0;
                end
            end
            OWN: begin
                if (rel_own) begin
                    rr_ptr_n = owner;
                    count_n  = '0;
                    if (oth_req) begin
                        owner_n = ~owner;
                    end else if (!own_req) begin
                        state_n = IDLE;
                    end
                end else if (accept) begin
                    count_n = count + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= REQ0;
            rr_ptr    <= REQ1;
            count     <= '0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rr_ptr    <= rr_ptr_n;
            count     <= count_n;
            r0_rvalid <= accept && (owner == REQ0);
            r1_rvalid <= accept && (owner == REQ1);
        end
    end

    assign r0_gnt   = (state == OWN) && (owner == REQ0);
    assign r1_gnt   = (state == OWN) && (owner == REQ1);
    assign busy     = (state != IDLE);
    assign mem_rd   = accept;
    assign mem_addr = accept ? own_addr : '0;
    assign rdata    = mem_data;

`ifdef GRAY_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r0_beats <= '0;
            r1_beats <= '0;
        end else begin
            if (accept && (owner == REQ0) && (r0_beats != 16'hFFFF))
                r0_beats <= r0_beats + 16'd1;
            if (accept && (owner == REQ1) && (r1_beats != 16'hFFFF))
                r1_beats <= r1_beats + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gray_mem_arbiter.sv
// Self-checking bench for gray_mem_arbiter: tenure-level reference model plus
// a read-return scoreboard drained by an independent monitor.
module tb_gray_mem_arbiter;

    localparam int MAXB = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        r0_req = 1'b0, r0_lock = 1'b0, r1_req = 1'b0, r1_lock = 1'b0;
    logic [13:0] r0_addr = '0, r1_addr = '0;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [7:0]  rdata;
    logic        mem_rd;
    logic [13:0] mem_addr;
    logic [7:0]  mem_data;
    logic        busy;
`ifdef GRAY_ARB_STATS_EN
    logic [15:0] r0_beats, r1_beats;
`endif

    gray_mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .r0_req    (r0_req),
        .r0_lock   (r0_lock),
        .r0_addr   (r0_addr),
        .r0_gnt    (r0_gnt),
        .r0_rvalid (r0_rvalid),
        .r1_req    (r1_req),
        .r1_lock   (r1_lock),
        .r1_addr   (r1_addr),
        .r1_gnt    (r1_gnt),
        .r1_rvalid (r1_rvalid),
        .rdata     (rdata),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
`ifdef GRAY_ARB_STATS_EN
        .r0_beats  (r0_beats),
        .r1_beats  (r1_beats),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16384];
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    int checks = 0;
    int failures = 0;

    // reference model: current owner (-1 none), beats in tenure, last owner
    int m_owner = -1;
    int m_beats = 0;
    int m_last  = 1;
    int m_prev  = -1;
    int m_cnt [2] = '{0, 0};
    int obs = -1;
    int rv0_seen = 0;

    int         exp_id [$];
    logic [7:0] exp_dat [$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit q0, input bit l0, input int a0,
                        input bit q1, input bit l1, input int a1, input bit rst);
        int o, ao;
        bit qo, lo, qx, acc;
        @(negedge clk);
        r0_req = q0; r0_lock = l0; r0_addr = 14'(a0);
        r1_req = q1; r1_lock = l1; r1_addr = 14'(a1);
        reset = rst;
        #1;
        o   = m_owner;
        qo  = (o == 1) ? q1 : q0;
        lo  = (o == 1) ? l1 : l0;
        ao  = (o == 1) ? a1 : a0;
        qx  = (o == 1) ? q0 : q1;
        acc = (o >= 0) && qo;
        chk("r0_gnt", int'(r0_gnt), int'(o == 0));
        chk("r1_gnt", int'(r1_gnt), int'(o == 1));
        chk("busy", int'(busy), int'(o >= 0));
        chk("mem_rd", int'(mem_rd), int'(acc));
        chk("mem_addr", int'(mem_addr), acc ? ao : 0);
        chk("r0_rvalid", int'(r0_rvalid), int'(m_prev == 0));
        chk("r1_rvalid", int'(r1_rvalid), int'(m_prev == 1));
`ifdef GRAY_ARB_STATS_EN
        chk("r0_beats", int'(r0_beats), m_cnt[0]);
        chk("r1_beats", int'(r1_beats), m_cnt[1]);
`endif
        obs = !mem_rd ? -1 : (r0_gnt ? 0 : (r1_gnt ? 1 : 2));
        if (acc && !rst) begin
            exp_id.push_back(o);
            exp_dat.push_back(mem[ao]);
        end
        if (rst) begin
            m_owner = -1; m_beats = 0; m_last = 1; m_prev = -1;
            m_cnt = '{0, 0};
        end else begin
            m_prev = acc ? o : -1;
            if (acc && m_cnt[o] < 65535) m_cnt[o]++;
            if (o < 0) begin
                if (q0 && q1) m_owner = 1 - m_last;
                else if (q0) m_owner = 0;
                else if (q1) m_owner = 1;
                m_beats = 0;
            end else begin
                if (acc) m_beats++;
                if ((!qo && !lo) || (acc && m_beats == MAXB)) begin
                    m_last  = o;
                    m_beats = 0;
                    if (qx) m_owner = 1 - o;
                    else if (!qo) m_owner = -1;
                end
            end
        end
    endtask

    function automatic int ra();
        return int'($urandom_range(0, 16383));
    endfunction

    // monitor: every presented read return is matched against the scoreboard
    initial begin
        int id;
        logic [7:0] d;
        forever begin
            @(negedge clk);
            #2;
            if (r0_rvalid === 1'b1 || r1_rvalid === 1'b1) begin
                if (r0_rvalid) rv0_seen++;
                if (r0_rvalid && r1_rvalid) begin
                    chk("rvalid_both", 1, 0);
                end else if (exp_id.size() == 0) begin
                    chk("rvalid_unexpected", 1, 0);
                end else begin
                    id = exp_id.pop_front();
                    d  = exp_dat.pop_front();
                    chk("rvalid_id", r1_rvalid ? 1 : 0, id);
                    chk("rdata", int'(rdata), int'(d));
                end
            end
        end
    end

    initial begin
        int addrs [3];
        int idx, n, gaps, rv_base;
        int seq [$];
        for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);

        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // single requester, addresses 129, 0, 1
        addrs = '{129, 0, 1};
        idx = 0;
        for (int k = 0; k < 10 && idx < 3; k++) begin
            step(1, 0, addrs[idx], 0, 0, 0, 0);
            if (obs == 0) idx++;
        end
        chk("single_beats", idx, 3);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);

        // tie after reset: strict 9/9 alternation starting with r0
        step(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 37; k++) begin
            step(1, 0, ra(), 1, 0, ra(), 0);
            if (obs >= 0) seq.push_back(obs);
        end
        chk("tie_beats", seq.size(), 36);
        for (int i = 0; i < seq.size(); i++) chk("tie_order", seq[i], (i / MAXB) % 2);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0);
`ifdef GRAY_ARB_STATS_EN
        chk("stats_r0", int'(r0_beats), 18);
        chk("stats_r1", int'(r1_beats), 18);
`endif

        // lock hold by r1 while r0 waits
        step(0, 0, 0, 0, 0, 0, 1);
        n = 0;
        for (int k = 0; k < 10 && n < 3; k++) begin
            step(0, 0, 0, 1, 0, ra(), 0);
            if (obs == 1) n++;
        end
        chk("lock_pre_beats", n, 3);
        repeat (4) begin
            step(1, 0, ra(), 0, 1, ra(), 0);
            chk("lock_r1_gnt", int'(r1_gnt), 1);
            chk("lock_r0_gnt", int'(r0_gnt), 0);
            chk("lock_mem_rd", int'(mem_rd), 0);
        end
        n = 0;
        for (int k = 0; k < 15; k++) begin
            step(1, 0, ra(), 1, 0, ra(), 0);
            if (obs == 1) n++;
            else break;
        end
        chk("lock_resume_beats", n, 6);
        chk("lock_handoff_r0", obs, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0);

        // burst limit with sole requester: 20 beats, no gaps
        step(0, 0, 0, 0, 0, 0, 1);
        rv_base = rv0_seen;
        n = 0; gaps = 0;
        for (int k = 0; k < 40 && n < 20; k++) begin
            step(1, 0, ra(), 0, 0, 0, 0);
            if (obs == 0) n++;
            else if (n > 0) gaps++;
        end
        chk("burst_beats", n, 20);
        chk("burst_gaps", gaps, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        chk("burst_rvalids", rv0_seen - rv_base, 20);

        // reset one cycle after the 5th accepted beat
        step(0, 0, 0, 0, 0, 0, 1);
        n = 0;
        for (int k = 0; k < 15 && n < 5; k++) begin
            step(1, 0, ra(), 0, 0, 0, 0);
            if (obs == 0) n++;
        end
        chk("rst_pre_beats", n, 5);
        step(1, 0, ra(), 0, 0, 0, 1);
        step(1, 0, ra(), 1, 0, ra(), 0);
        chk("rst_gnt", int'(r0_gnt | r1_gnt), 0);
        chk("rst_rvalid", int'(r0_rvalid | r1_rvalid), 0);
        chk("rst_busy", int'(busy), 0);
        step(1, 0, ra(), 1, 0, ra(), 0);
        chk("rst_r0_priority", int'(r0_gnt), 1);

        // randomized traffic with occasional lock and reset
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, ra(),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, ra(),
                 $urandom_range(0, 199) == 0);
        end
        repeat (4) step(0, 0, 0, 0, 0, 0, 0);
        chk("scoreboard_empty", exp_id.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
